// File: rtl/fir_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_seq_ctrl_if
//   Bundles the configuration, sample and datapath-control signals of the FIR
//   sequencer so the controller and its neighbours connect through one port.
//
//   Handshake (sample path): a sample transfers in any cycle where
//   sampleValid and sampleReady are both high at the rising clock edge.
//   The source holds sampleData stable while sampleValid is high and the
//   transfer has not yet happened. sampleReady never depends on sampleValid.
//
//   Modports
//     master : sample/config source side (drives cfg*, start, stop, sample*)
//     slave  : the controller (drives cfgErr, sampleReady, shift*, coefs,
//              accelerateEn, busy)
// ---------------------------------------------------------------------------
interface fir_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
  // configuration port
  logic                  cfgWe;
  logic [ADDR_WIDTH-1:0] cfgAddr;
  logic [DATA_WIDTH-1:0] cfgData;
  logic                  cfgErr;

  // run control
  logic                  start;
  logic                  stop;

  // sample stream
  logic                  sampleValid;
  logic [DATA_WIDTH-1:0] sampleData;
  logic                  sampleReady;

  // datapath control
  logic                  shiftEn;
  logic [DATA_WIDTH-1:0] shiftData;
  logic                  shiftClr;
  logic [DATA_WIDTH-1:0] coefs [NUM_REGS];
  logic                  accelerateEn;
  logic                  busy;

  modport master (
    output cfgWe, cfgAddr, cfgData, start, stop, sampleValid, sampleData,
    input  cfgErr, sampleReady, shiftEn, shiftData, shiftClr, coefs,
           accelerateEn, busy
  );

  modport slave (
    input  cfgWe, cfgAddr, cfgData, start, stop, sampleValid, sampleData,
    output cfgErr, sampleReady, shiftEn, shiftData, shiftClr, coefs,
           accelerateEn, busy
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_seq_ctrl
//   Sequencer and configuration front-end for the FIR datapath. Holds the
//   coefficient bank, admits samples through a valid/ready handshake, clears
//   the delay line when filtering is armed, and withholds accelerateEn until
//   the delay line holds NUM_REGS fresh samples.
//
//   Ports
//     clk        : single clock, all state on posedge
//     rst        : synchronous reset, active-high
//     bus        : fir_seq_ctrl_if.slave (config, run control, samples,
//                  datapath control outputs)
//     dbg_state  : current FSM state (IDLE=0, FLUSH=1, WARMUP=2, RUN=3)
//
//   bus parameters must match DATA_WIDTH / NUM_REGS / ADDR_WIDTH here.
//   Only shiftEn and shiftData are combinational; every other output comes
//   from a register or from the state register alone.
// ---------------------------------------------------------------------------
module fir_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  fir_seq_ctrl_if.slave       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  // Fill counter counts up to NUM_REGS and then stays put; one extra bit
  // over the address width so it can represent NUM_REGS itself.
  localparam int                CNT_W     = $clog2(NUM_REGS + 1);
  localparam logic [CNT_W-1:0]  LAST_FILL = CNT_W'(NUM_REGS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic [DATA_WIDTH-1:0]   coef_q [NUM_REGS];
  logic                    accel_q;
  logic                    cfg_err_q;

  logic                    ready;
  logic                    accept;
  logic                    fire;
  logic                    cfg_ok;

  // -------------------------------------------------------------------------
  // Handshake: ready comes from state only, so a source may legally wait for
  // ready before raising valid without creating a loop.
  // -------------------------------------------------------------------------
  always_comb begin
    ready  = (state_q == WARMUP) || (state_q == RUN);
    accept = bus.sampleValid && ready;
  end

  // Coefficient writes land only in IDLE and only for existing taps.
  always_comb begin
    cfg_ok = bus.cfgWe && (state_q == IDLE) && (32'(bus.cfgAddr) < NUM_REGS);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  //   stop outranks start and outranks firing: a sample taken in the same
  //   cycle as stop still reaches the delay line but produces no result.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) state_d = FLUSH;
      end
      FLUSH: begin
        fill_d  = '0;
        state_d = bus.stop ? IDLE : WARMUP;
      end
      WARMUP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (accept) begin
          fill_d = fill_q + 1'b1;
          // The sample that completes the delay line is already a valid
          // output sample, so it fires immediately.
          if (fill_q == LAST_FILL) begin
            state_d = RUN;
            fire    = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop) state_d = IDLE;
        else          fire    = accept;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters, coefficient bank and registered pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      accel_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) coef_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      accel_q   <= fire;
      cfg_err_q <= bus.cfgWe && !cfg_ok;
      if (cfg_ok) coef_q[bus.cfgAddr] <= bus.cfgData;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.sampleReady  = ready;
  assign bus.shiftEn      = accept;
  assign bus.shiftData    = bus.sampleData;
  assign bus.shiftClr     = (state_q == FLUSH);
  assign bus.coefs        = coef_q;
  assign bus.accelerateEn = accel_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.cfgErr       = cfg_err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_seq_ctrl
//   Scenario tasks drive the controller through reset, coefficient load,
//   warm-up, gapped streaming, stop races and mid-run reset. Every expected
//   delay-line write and every expected accelerateEn pulse is queued when the
//   stimulus is driven; a negedge monitor pops and compares as they appear.
// ---------------------------------------------------------------------------
module tb_fir_seq_ctrl;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int AW = 2;

  localparam logic [1:0] S_IDLE = 2'd0, S_FLUSH = 2'd1, S_WARMUP = 2'd2, S_RUN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) bus ();
  logic [1:0] dbg_state;

  fir_seq_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] shift_q[$];
  logic [DW-1:0] acc_q[$];
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  // accelerateEn in cycle N+1 must match a queued sample accepted in cycle N.
  always @(negedge clk) begin
    logic [DW-1:0] exp_v;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.accelerateEn === 1'b1) begin
        n_cmp++;
        if (acc_q.size() == 0) begin
          n_err++;
          $display("FAIL acc_unexpected: accelerateEn=1 (prev sample %0d) required no pulse", prev_data);
        end else begin
          exp_v = acc_q.pop_front();
          if (!prev_valid || prev_data !== exp_v) begin
            n_err++;
            $display("FAIL acc_sample: pulse after sample %0d (prev shiftEn=%0b) required after %0d",
                     prev_data, prev_valid, exp_v);
          end
        end
      end
      if (bus.shiftEn === 1'b1) begin
        n_cmp++;
        if (shift_q.size() == 0) begin
          n_err++;
          $display("FAIL shift_unexpected: shiftEn=1 data=%0d required no shift", bus.shiftData);
        end else begin
          exp_v = shift_q.pop_front();
          if (bus.shiftData !== exp_v) begin
            n_err++;
            $display("FAIL shift_data: shiftData=%0d required %0d", bus.shiftData, exp_v);
          end
        end
      end
      prev_valid = (bus.shiftEn === 1'b1);
      prev_data  = bus.shiftData;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.cfgWe       = 1'b0;
    bus.cfgAddr     = '0;
    bus.cfgData     = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.sampleValid = 1'b0;
    bus.sampleData  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample per cycle for n cycles; the last one is expected to fire.
  task automatic warm_samples(input int n);
    for (int k = 0; k < n; k++) begin
      bus.sampleValid = 1'b1;
      bus.sampleData  = DW'($urandom_range(1, 16'hffff));
      shift_q.push_back(bus.sampleData);
      if (k == n - 1) acc_q.push_back(bus.sampleData);
      @(negedge clk);
      n_cmp++;
      if (bus.accelerateEn !== 1'b0) begin
        n_err++;
        $display("FAIL warm_early_acc: sample %0d accelerateEn=%b required 0", k, bus.accelerateEn);
      end
      step();
    end
    set_idle();
  endtask

  task automatic drain_check(input string name);
    repeat (2) step();
    n_cmp++;
    if (shift_q.size() != 0 || acc_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: pending shifts=%0d pulses=%0d required 0/0", name, shift_q.size(), acc_q.size());
      shift_q.delete();
      acc_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] flags;
    set_idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    flags = {bus.sampleReady, bus.shiftEn, bus.shiftClr, bus.accelerateEn, bus.busy, bus.cfgErr};
    n_cmp++;
    if (flags !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: rdy/sh/clr/acc/busy/err=%b required 000000", flags);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, S_IDLE);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (bus.coefs[i] !== '0) begin
        n_err++;
        $display("FAIL reset_coef: coefs[%0d]=%0d required 0", i, bus.coefs[i]);
      end
    end
    step();
  endtask

  task automatic test_coef_load();
    for (int i = 0; i <= NR; i++) begin
      if (i < NR) begin
        bus.cfgWe   = 1'b1;
        bus.cfgAddr = AW'(i);
        bus.cfgData = DW'(i + 1);
      end else begin
        set_idle();
      end
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus.coefs[i-1] !== DW'(i) || bus.cfgErr !== 1'b0) begin
          n_err++;
          $display("FAIL coef_load: coefs[%0d]=%0d cfgErr=%b required %0d/0", i - 1, bus.coefs[i-1], bus.cfgErr, i);
        end
      end
      step();
    end
  endtask

  task automatic test_idle_controls();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || bus.busy !== 1'b0 || bus.shiftClr !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_idle: state=%0d busy=%b clr=%b required 0/0/0", dbg_state, bus.busy, bus.shiftClr);
    end
    step();
    set_idle();
  endtask

  task automatic test_warmup();
    logic [1:0] exp_st;
    bus.start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || bus.shiftClr !== 1'b0) begin
      n_err++;
      $display("FAIL warm_start_cycle: state=%0d clr=%b required 0/0", dbg_state, bus.shiftClr);
    end
    step();
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_FLUSH || bus.shiftClr !== 1'b1 || bus.sampleReady !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL warm_flush: state=%0d clr=%b rdy=%b busy=%b required 1/1/0/1",
               dbg_state, bus.shiftClr, bus.sampleReady, bus.busy);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      bus.sampleValid = 1'b1;
      bus.sampleData  = DW'(10 * (k + 1));
      shift_q.push_back(bus.sampleData);
      if (k >= 3) acc_q.push_back(bus.sampleData);
      exp_st = (k == 4) ? S_RUN : S_WARMUP;
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== exp_st || bus.shiftClr !== 1'b0 || bus.sampleReady !== 1'b1) begin
        n_err++;
        $display("FAIL warm_sample: k=%0d state=%0d clr=%b rdy=%b required %0d/0/1",
                 k, dbg_state, bus.shiftClr, bus.sampleReady, exp_st);
      end
      step();
    end
    set_idle();
    drain_check("warmup");
  endtask

  task automatic test_cfg_err();
    bus.cfgWe   = 1'b1;
    bus.cfgAddr = AW'(2);
    bus.cfgData = DW'(99);
    @(negedge clk);
    n_cmp++;
    if (bus.cfgErr !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_early: cfgErr=%b required 0", bus.cfgErr);
    end
    step();
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.cfgErr !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_err_pulse: cfgErr=%b required 1", bus.cfgErr);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.cfgErr !== 1'b0 || bus.coefs[2] !== DW'(3)) begin
      n_err++;
      $display("FAIL cfg_err_after: cfgErr=%b coefs[2]=%0d required 0/3", bus.cfgErr, bus.coefs[2]);
    end
    step();
  endtask

  task automatic test_gaps();
    int pat [5] = '{1, 0, 0, 1, 1};
    for (int k = 0; k < 5; k++) begin
      bus.sampleValid = pat[k][0];
      bus.sampleData  = DW'($urandom_range(1, 16'hffff));
      bus.start       = (k == 1);
      if (pat[k] == 1) begin
        shift_q.push_back(bus.sampleData);
        acc_q.push_back(bus.sampleData);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.shiftEn !== pat[k][0]) begin
        n_err++;
        $display("FAIL gaps_shiften: k=%0d shiftEn=%b required %0d", k, bus.shiftEn, pat[k]);
      end
      step();
    end
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_RUN) begin
      n_err++;
      $display("FAIL gaps_state: state=%0d required %0d", dbg_state, S_RUN);
    end
    drain_check("gaps");
  endtask

  task automatic test_stop_race();
    bus.stop        = 1'b1;
    bus.sampleValid = 1'b1;
    bus.sampleData  = DW'(77);
    shift_q.push_back(DW'(77));
    @(negedge clk);
    n_cmp++;
    if (bus.shiftEn !== 1'b1 || bus.shiftData !== DW'(77)) begin
      n_err++;
      $display("FAIL stop_shift: shiftEn=%b shiftData=%0d required 1/77", bus.shiftEn, bus.shiftData);
    end
    step();
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || bus.sampleReady !== 1'b0 || bus.accelerateEn !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_after: state=%0d rdy=%b acc=%b busy=%b required 0/0/0/0",
               dbg_state, bus.sampleReady, bus.accelerateEn, bus.busy);
    end
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    warm_samples(NR);
    drain_check("restart");
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    set_idle();
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || bus.accelerateEn !== 1'b0 || bus.sampleReady !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state: state=%0d acc=%b rdy=%b required 0/0/0", dbg_state, bus.accelerateEn, bus.sampleReady);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (bus.coefs[i] !== '0) begin
        n_err++;
        $display("FAIL midrst_coef: coefs[%0d]=%0d required 0", i, bus.coefs[i]);
      end
    end
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    warm_samples(NR);
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_RUN) begin
      n_err++;
      $display("FAIL midrst_rewarm: state=%0d required %0d", dbg_state, S_RUN);
    end
    drain_check("midrst");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + final report ----------------
  initial begin
    set_idle();
    test_reset();
    test_coef_load();
    test_idle_controls();
    test_warmup();
    test_cfg_err();
    test_gaps();
    test_stop_race();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
